// File: rtl/gf_mont_pkg.sv
// Shared definitions for the GF(p) Montgomery ALU: operation codes, FSM states
// and the width helper used to size the iteration counter.
package gf_mont_pkg;

  typedef enum logic [1:0] {
    OP_ADD  = 2'b00,
    OP_SUB  = 2'b01,
    OP_MMUL = 2'b10,
    OP_MSQR = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ADDSUB = 2'b01,
    LOOP   = 2'b10,
    FIX    = 2'b11
  } state_e;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/gf_mont_step.sv
// One radix-2 Montgomery iteration: T + a_i*b, made even by adding p, then halved.
module gf_mont_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH+1:0] t,
  input  logic             a_i,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] p,
  output logic [WIDTH+1:0] t_next
);

  logic [WIDTH+1:0] sum_b;
  logic [WIDTH+1:0] sum_p;

  // T < 2p on entry keeps T + b + p below 4p, so WIDTH+2 bits never overflow
  always_comb begin
    sum_b  = t + (a_i ? {2'b00, b} : '0);
    sum_p  = sum_b[0] ? (sum_b + {2'b00, p}) : sum_b;
    t_next = {1'b0, sum_p[WIDTH+1:1]};
  end

endmodule

// File: rtl/gf_mont_alu.sv
// GF(p) add/sub/Montgomery multiply/square engine with start/busy/done handshake.
// Optional operand validation at accept is enabled by GF_MONT_ALU_INPUT_CHECK_EN.
module gf_mont_alu
  import gf_mont_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] p,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             err
);

  localparam int TW = WIDTH + 2;
  localparam int CW = clog2(WIDTH);

  state_e           state_q, state_d;
  op_e              op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, p_q, p_d, res_q, res_d;
  logic [TW-1:0]    t_q, t_d, t_step;
  logic [TW-1:0]    a_x, b_x, p_x;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             busy_q, busy_d, done_q, done_d, err_q, err_d, inv_q, inv_d;
  logic             inv_req;

  assign a_x = {2'b00, a_q};
  assign b_x = {2'b00, b_q};
  assign p_x = {2'b00, p_q};

  always_comb begin
`ifdef GF_MONT_ALU_INPUT_CHECK_EN
    inv_req = ~p[0] | (a >= p) | ((op != OP_MSQR) & (b >= p));
`else
    inv_req = 1'b0;
`endif
  end

  gf_mont_step #(.WIDTH(WIDTH)) u_step (
    .t      (t_q),
    .a_i    (a_q[cnt_q]),
    .b      (b_q),
    .p      (p_q),
    .t_next (t_step)
  );

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    p_d     = p_q;
    res_d   = res_q;
    t_d     = t_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    err_d   = err_q;
    inv_d   = inv_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          op_d   = op_e'(op);
          a_d    = a;
          b_d    = (op == OP_MSQR) ? a : b;
          p_d    = p;
          t_d    = '0;
          cnt_d  = '0;
          busy_d = 1'b1;
          inv_d  = inv_req;
          if (inv_req)                              state_d = FIX;
          else if ((op == OP_ADD) || (op == OP_SUB)) state_d = ADDSUB;
          else                                      state_d = LOOP;
        end
      end
      ADDSUB: begin
        if (op_q == OP_ADD)  t_d = a_x + b_x;
        else if (a_q < b_q)  t_d = a_x - b_x + p_x;
        else                 t_d = a_x - b_x;
        state_d = FIX;
      end
      LOOP: begin
        t_d   = t_step;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) state_d = FIX;
      end
      FIX: begin
        // Rejected requests report err with a zero result instead of T
        if (inv_q) begin
          res_d = '0;
          err_d = 1'b1;
        end else begin
          res_d = (t_q >= p_x) ? WIDTH'(t_q - p_x) : t_q[WIDTH-1:0];
          err_d = 1'b0;
        end
        done_d  = 1'b1;
        busy_d  = 1'b0;
        inv_d   = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      op_q    <= OP_ADD;
      a_q     <= '0;
      b_q     <= '0;
      p_q     <= '0;
      res_q   <= '0;
      t_q     <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      inv_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      p_q     <= p_d;
      res_q   <= res_d;
      t_q     <= t_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      inv_q   <= inv_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = res_q;
  assign err    = err_q;

endmodule
